// File: rtl/tomasulo_rob_commit_pkg.sv
// rtl/tomasulo_rob_commit_pkg.sv - shared ROB constants, opcodes and entry type
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 3;
  localparam int DATA_W    = 16;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNEQ  = 4'd7;

  typedef struct packed {
    logic              busy;
    logic              ready;
    logic [3:0]        func;
    logic [3:0]        rd;
    logic [3:0]        pc;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  function automatic logic is_branch(input logic [3:0] func);
    return (func == OP_BEQ) || (func == OP_BNEQ);
  endfunction

endpackage

// File: rtl/tomasulo_rob_commit_if.sv
// rtl/tomasulo_rob_commit_if.sv - issue/CDB/commit bundle; ROB_FORWARD_EN adds operand forwarding
interface tomasulo_rob_commit_if;
  import tomasulo_pkg::*;

  logic                 alloc_valid;
  logic [3:0]           alloc_func;
  logic [3:0]           alloc_rd;
  logic [3:0]           alloc_pc;
  logic                 alloc_ready;
  logic [ROB_TAG_W-1:0] alloc_tag;

  logic                 cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0]    cdb_data;

  logic                 commit_valid;
  logic [ROB_TAG_W-1:0] commit_tag;
  logic [3:0]           commit_rd;
  logic [DATA_W-1:0]    commit_data;
  logic                 commit_store;
  logic                 flush_valid;
  logic [3:0]           flush_pc;
  logic [ROB_TAG_W:0]   rob_count;

`ifdef ROB_FORWARD_EN
  logic [0:1][ROB_TAG_W-1:0] src_tag;
  logic [0:1]                src_ready;
  logic [0:1][DATA_W-1:0]    src_data;
`endif

  modport master (
    output alloc_valid, alloc_func, alloc_rd, alloc_pc, cdb_valid, cdb_tag, cdb_data,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_data,
           commit_store, flush_valid, flush_pc, rob_count
`ifdef ROB_FORWARD_EN
    , output src_tag, input src_ready, src_data
`endif
  );

  modport slave (
    input  alloc_valid, alloc_func, alloc_rd, alloc_pc, cdb_valid, cdb_tag, cdb_data,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_data,
           commit_store, flush_valid, flush_pc, rob_count
`ifdef ROB_FORWARD_EN
    , input src_tag, output src_ready, src_data
`endif
  );

endinterface

// File: rtl/tomasulo_rob_commit.sv
// rtl/tomasulo_rob_commit.sv - reorder buffer with in-order commit and mispredict flush (ROB_FORWARD_EN optional)
module tomasulo_rob_commit
  import tomasulo_pkg::*;
(
  input logic                  clk1,
  input logic                  rst_n,
  tomasulo_rob_commit_if.slave rob_if
);

  localparam int TAG_W = ROB_TAG_W;
  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(ROB_DEPTH);

  rob_entry_t        rob_q [ROB_DEPTH];
  rob_entry_t        rob_d [ROB_DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              commit_valid_q, commit_store_q, flush_valid_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [3:0]        commit_rd_q, flush_pc_q;
  logic [DATA_W-1:0] commit_data_q;

  rob_entry_t        head_e;
  logic              alloc_ready, do_commit, do_flush, do_alloc, do_cdb;

  assign head_e      = rob_q[head_q];
  // Readiness looks only at registered occupancy, so a full ROB never admits
  // an allocation even when the head retires in the same cycle.
  assign alloc_ready = (count_q < CNT_FULL);
  assign do_commit   = (count_q != '0) && head_e.busy && head_e.ready;
  assign do_flush    = do_commit && is_branch(head_e.func) && head_e.data[0];
  assign do_alloc    = rob_if.alloc_valid && alloc_ready && !do_flush;
  assign do_cdb      = rob_if.cdb_valid && rob_q[rob_if.cdb_tag].busy && !do_flush;

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_d[i] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_cdb) begin
        rob_d[rob_if.cdb_tag].data  = rob_if.cdb_data;
        rob_d[rob_if.cdb_tag].ready = 1'b1;
      end
      if (do_commit) begin
        rob_d[head_q].busy  = 1'b0;
        rob_d[head_q].ready = 1'b0;
        head_d = head_q + PTR_ONE;
      end
      if (do_alloc) begin
        rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, func: rob_if.alloc_func,
                          rd: rob_if.alloc_rd, pc: rob_if.alloc_pc, data: '0};
        tail_d = tail_q + PTR_ONE;
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_data_q  <= '0;
      commit_store_q <= 1'b0;
      flush_valid_q  <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      commit_valid_q <= do_commit;
      commit_tag_q   <= do_commit ? head_q : '0;
      commit_rd_q    <= do_commit ? head_e.rd : '0;
      commit_data_q  <= do_commit ? head_e.data : '0;
      commit_store_q <= do_commit && (head_e.func == OP_STORE);
      flush_valid_q  <= do_flush;
      // Branch target is pc + immediate carried in rd, wrapping in 4 bits.
      flush_pc_q     <= do_flush ? (head_e.pc + head_e.rd) : '0;
    end
  end

  assign rob_if.alloc_ready  = alloc_ready;
  assign rob_if.alloc_tag    = tail_q;
  assign rob_if.rob_count    = count_q;
  assign rob_if.commit_valid = commit_valid_q;
  assign rob_if.commit_tag   = commit_tag_q;
  assign rob_if.commit_rd    = commit_rd_q;
  assign rob_if.commit_data  = commit_data_q;
  assign rob_if.commit_store = commit_store_q;
  assign rob_if.flush_valid  = flush_valid_q;
  assign rob_if.flush_pc     = flush_pc_q;

`ifdef ROB_FORWARD_EN
  // A same-cycle CDB broadcast wins over the stored entry so issue never misses it.
  always_comb begin
    rob_if.src_ready = '0;
    rob_if.src_data  = '0;
    for (int i = 0; i < 2; i++) begin
      if (rob_if.cdb_valid && (rob_if.cdb_tag == rob_if.src_tag[i])) begin
        rob_if.src_ready[i] = 1'b1;
        rob_if.src_data[i]  = rob_if.cdb_data;
      end else begin
        rob_if.src_ready[i] = rob_q[rob_if.src_tag[i]].busy & rob_q[rob_if.src_tag[i]].ready;
        rob_if.src_data[i]  = rob_q[rob_if.src_tag[i]].data;
      end
    end
  end
`endif

endmodule

// File: doc/tomasulo_rob_commit.md
Name: tomasulo_rob_commit

Overview:
- Reorder buffer and in-order commit unit; the retire end of the issue path.
- Issue allocates one entry per instruction in program order and receives a tag.
- Execution units return results on the common data bus (CDB) by tag.
- The head entry retires one per cycle: register writeback, store release, or branch-mispredict flush. Branches are predicted not-taken at issue.

Parameters:
- DEPTH, 8, number of ROB entries (power of two).
- TAG_W, 3, tag/pointer width, log2(DEPTH).
- DATA_W, 16, result width.

Ports:
- clk1  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  issue requests an entry
- alloc_func  in  4  opcode (0000 add … 0111 bneq)
- alloc_rd  in  4  destination register; branch immediate for beq/bneq
- alloc_pc  in  4  pc of the allocated instruction
- alloc_ready  out  1  entry available (count < DEPTH)
- alloc_tag  out  TAG_W  tag given to this allocation (= tail)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  entry being completed
- cdb_data  in  DATA_W  result; for branches bit0 = taken
- commit_valid  out  1  one-cycle retire pulse
- commit_tag  out  TAG_W  retired entry
- commit_rd  out  4  destination register
- commit_data  out  DATA_W  result value
- commit_store  out  1  retired entry is a store (LSQ performs the write)
- flush_valid  out  1  one-cycle mispredict pulse
- flush_pc  out  4  redirect target
- rob_count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (async, rst_n=0): head=tail=0, count=0, all busy/ready bits cleared. commit_*, flush_valid and flush_pc are 0. alloc_ready=1.
- Entry fields: busy, ready, func, rd, pc, data.
- Allocate: on a clk1 edge with alloc_valid & alloc_ready, the entry at tail is written as busy=1, ready=0. tail increments, wrapping DEPTH-1→0. alloc_tag is combinational = tail.
- alloc_ready is derived from registered count only. When full, a commit in the same cycle does not admit a same-cycle allocation.
- A stalled allocation (alloc_valid & !alloc_ready) is ignored; issue holds its request.
- CDB: on an edge with cdb_valid where entry[cdb_tag].busy=1, that entry gets data=cdb_data, ready=1. A CDB to a non-busy entry is ignored.
- Commit: on each edge, if entry[head] is busy & ready (registered state before this edge), retire it.
  - Registered outputs pulse for one cycle after the edge.
  - busy is cleared and head increments with wrap.
  - Latency: a CDB write at edge N gives commit_valid high after edge N+1.
- Func decode at commit:
  - add/sub/mul/div/load: commit_valid=1, commit_store=0.
  - store: commit_valid=1, commit_store=1.
  - beq/bneq, not taken: commit_valid=1, no redirect.
  - beq/bneq, taken (data[0]=1): commit_valid=1, flush_valid=1, flush_pc = pc + rd, 4-bit modulo.
- Flush: at the same edge that produces flush_valid, every entry is cleared and head=tail=count=0. An allocation or CDB in that cycle is dropped.
- count: +1 on allocate, −1 on commit, unchanged when both occur, 0 on flush.
- Empty (count=0): no commit; head is not checked.

Optional Feature:
- Macro ROB_FORWARD_EN.
- Defined: adds ports src_tag[0:1] in TAG_W and src_ready[0:1] out 1, src_data[0:1] out DATA_W. The data outputs are combinational entry[src_tag].data. src_ready = busy & ready, or the same-cycle CDB match (cdb_valid & cdb_tag==src_tag, data from cdb_data). This lets issue capture completed-but-uncommitted operands.
- Undefined: these ports are absent; issue waits for regbank writeback.

Decomposition:
- Shared package tomasulo_pkg:
  - opcode constants OP_ADD…OP_BNEQ (4-bit)
  - ROB_DEPTH=8, ROB_TAG_W=3, DATA_W=16
  - rob_entry_t struct (busy, ready, func, rd, pc, data)
- Single module; no sub-module needed. Pointer wrap uses TAG_W-bit natural overflow.

Test Plan:
- Reset mid-operation with 3 entries busy → next cycle count=0, alloc_tag=0, alloc_ready=1, no commit_valid.
- Allocate add rd=5 (tag0), then CDB tag0 data=0x0042 → commit_valid one cycle later with commit_rd=5, commit_data=0x0042, commit_tag=0.
- Allocate tags 0,1,2; CDB 2 then 1 then 0 → commits tags 0,1,2 in order on consecutive cycles after tag0's CDB.
- Allocate 8 → alloc_ready=0, rob_count=8. Assert alloc_valid with commit of head same cycle → allocation refused. Next cycle alloc_tag=0 (wrapped) accepted.
- beq pc=3 imm(rd)=4 as tag0, add as tag1 completed first; CDB tag0 data bit0=1 → flush_valid, flush_pc=7, tag1 never commits, count=0.
- Store tag0 completed → commit_valid=1, commit_store=1. With ROB_FORWARD_EN: src_tag=1 with same-cycle CDB tag1 data=0x00AA → src_ready=1, src_data=0x00AA.
